// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-master I2C register-access controller.
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR_W,
    ACK_A,
    REG,
    ACK_R,
    WDATA,
    ACK_D,
    RSTART,
    ADDR_R,
    ACK_AR,
    RDATA,
    MNACK,
    STOP,
    DONE
  } i2c_state_t;

  // R/W bit appended to the 7-bit slave address
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Quarter-period phases within one SCL bit slot
  localparam logic [1:0] PH_LOW    = 2'd0;
  localparam logic [1:0] PH_RISE   = 2'd1;
  localparam logic [1:0] PH_SAMPLE = 2'd2;
  localparam logic [1:0] PH_HIGH   = 2'd3;

endpackage

// File: rtl/i2c_if.sv
// Host-side command interface of the I2C controller, plus the FSM state for observation.
interface i2c_if
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) ();

  // Handshake: newTXN is a level request, taken only while the controller is
  // idle; busy is high from the clock after acceptance until the return to
  // idle; done pulses for one clock at the end (success or NACK abort), and
  // dataOut/ack_err are valid in that cycle. If newTXN is still high when the
  // controller returns to idle, the next transaction starts immediately.
  logic                  wrEn;
  logic                  newTXN;
  logic [DATA_WIDTH-2:0] slvAddr;
  logic [DATA_WIDTH-1:0] regAddr;
  logic [DATA_WIDTH-1:0] dataIn;
  logic [DATA_WIDTH-1:0] dataOut;
  logic                  busy;
  logic                  done;
  logic                  ack_err;
  i2c_state_t            state;

  modport master (
    output wrEn, newTXN, slvAddr, regAddr, dataIn,
    input  dataOut, busy, done, ack_err, state
  );

  modport slave (
    input  wrEn, newTXN, slvAddr, regAddr, dataIn,
    output dataOut, busy, done, ack_err, state
  );

endinterface

// File: rtl/i2c_clk_gen.sv
// Quarter-period tick generator: one tick every CLK_DIV clocks and a 2-bit phase
// that advances on each tick; both are held at zero while disabled.
module i2c_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       tick,
  output logic [1:0] phase
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 2'd0;
    end else if (cnt == LAST) begin
      cnt   <= '0;
      phase <= phase + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_controller.sv
// Single-master I2C controller: one register write or one register read per
// transaction, open-drain SDA, push-pull SCL, no clock stretching.
module i2c_controller
  import i2c_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4
) (
  input  logic  clk,
  input  logic  rst,
  i2c_if.slave  host,
  output logic  scl,
  inout  wire   sda
);

  localparam int DW = DATA_WIDTH;
  localparam int BW = (DW > 2) ? $clog2(DW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(DW - 1);

  i2c_state_t state, state_next;

  logic          tick;
  logic [1:0]    phase;
  logic          gen_en;
  logic          slot_end;
  logic          last_bit;
  logic          accept;
  logic          ack_slot;
  logic          sda_in;
  logic          sda_oe;
  logic          scl_c;
  logic          sda_oe_c;

  logic          wr_q;
  logic [DW-2:0] slv_q;
  logic [DW-1:0] reg_q;
  logic [DW-1:0] data_q;
  logic [DW-1:0] shift;
  logic [DW-1:0] rx;
  logic [DW-1:0] dout;
  logic [BW-1:0] bit_cnt;
  logic          busy_q;
  logic          ack_err_q;

  // Open drain: only ever pull low or release
  assign sda    = sda_oe ? 1'b0 : 1'bz;
  assign sda_in = sda;

  assign gen_en   = (state != IDLE) && (state != DONE);
  assign slot_end = tick && (phase == PH_HIGH);
  assign last_bit = (bit_cnt == '0);
  assign accept   = (state == IDLE) && host.newTXN;
  assign ack_slot = (state == ACK_A) || (state == ACK_R) ||
                    (state == ACK_D) || (state == ACK_AR);

  i2c_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (gen_en),
    .tick  (tick),
    .phase (phase)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // A NACK on any ACK slot skips the remaining bytes and goes straight to STOP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (host.newTXN) state_next = START;
      START:  if (slot_end) state_next = ADDR_W;
      ADDR_W: if (slot_end && last_bit) state_next = ACK_A;
      ACK_A:  if (slot_end) state_next = ack_err_q ? STOP : REG;
      REG:    if (slot_end && last_bit) state_next = ACK_R;
      ACK_R:  if (slot_end) state_next = ack_err_q ? STOP : (wr_q ? WDATA : RSTART);
      WDATA:  if (slot_end && last_bit) state_next = ACK_D;
      ACK_D:  if (slot_end) state_next = STOP;
      RSTART: if (slot_end) state_next = ADDR_R;
      ADDR_R: if (slot_end && last_bit) state_next = ACK_AR;
      ACK_AR: if (slot_end) state_next = ack_err_q ? STOP : RDATA;
      RDATA:  if (slot_end && last_bit) state_next = MNACK;
      MNACK:  if (slot_end) state_next = STOP;
      STOP:   if (slot_end) state_next = DONE;
      DONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Bus levels per phase; START/RSTART pull SDA low while SCL stays high,
  // STOP releases SDA while SCL is high.
  always_comb begin
    scl_c    = 1'b1;
    sda_oe_c = 1'b0;
    case (state)
      START: begin
        sda_oe_c = (phase == PH_SAMPLE) || (phase == PH_HIGH);
      end
      RSTART: begin
        scl_c    = (phase != PH_LOW);
        sda_oe_c = (phase == PH_SAMPLE) || (phase == PH_HIGH);
      end
      ADDR_W, REG, WDATA, ADDR_R: begin
        scl_c    = (phase != PH_LOW);
        sda_oe_c = ~shift[DW-1];
      end
      ACK_A, ACK_R, ACK_D, ACK_AR, RDATA, MNACK: begin
        scl_c = (phase != PH_LOW);
      end
      STOP: begin
        scl_c    = (phase != PH_LOW);
        sda_oe_c = (phase == PH_LOW) || (phase == PH_RISE);
      end
      default: begin
        scl_c    = 1'b1;
        sda_oe_c = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scl       <= 1'b1;
      sda_oe    <= 1'b0;
      busy_q    <= 1'b0;
      ack_err_q <= 1'b0;
      wr_q      <= 1'b0;
      slv_q     <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      shift     <= '0;
      rx        <= '0;
      dout      <= '0;
      bit_cnt   <= '0;
    end else begin
      scl    <= scl_c;
      sda_oe <= sda_oe_c;

      if (accept) begin
        busy_q    <= 1'b1;
        ack_err_q <= 1'b0;
        wr_q      <= host.wrEn;
        slv_q     <= host.slvAddr;
        reg_q     <= host.regAddr;
        data_q    <= host.dataIn;
      end else if (state == DONE) begin
        busy_q <= 1'b0;
      end

      if (tick && (phase == PH_SAMPLE)) begin
        if (ack_slot && sda_in) ack_err_q <= 1'b1;
        if (state == RDATA)     rx        <= {rx[DW-2:0], sda_in};
      end

      if (slot_end) begin
        if (state_next != state) begin
          bit_cnt <= LAST_BIT;
          case (state_next)
            ADDR_W:  shift <= {slv_q, RW_WRITE};
            REG:     shift <= reg_q;
            WDATA:   shift <= data_q;
            ADDR_R:  shift <= {slv_q, RW_READ};
            default: shift <= shift;
          endcase
        end else begin
          bit_cnt <= bit_cnt - 1'b1;
          shift   <= {shift[DW-2:0], 1'b0};
        end
        // rx already holds the last bit: it was shifted in at this slot's sample phase
        if ((state == RDATA) && last_bit) dout <= rx;
      end
    end
  end

  assign host.busy    = busy_q;
  assign host.done    = (state == DONE);
  assign host.ack_err = ack_err_q;
  assign host.dataOut = dout;
  assign host.state   = state;

endmodule

// File: tb/tb_i2c_controller.sv
// Directed bench for i2c_controller: behavioural I2C slave/bus monitor, one task per scenario.
module tb_i2c_controller;
  import i2c_pkg::*;

  localparam int DW      = 8;
  localparam int CLK_DIV = 4;
  localparam int SLOT    = 4 * CLK_DIV;
  localparam int TIMEOUT = 3000;
  localparam logic [9:0] TOK_START = 10'h200;
  localparam logic [9:0] TOK_STOP  = 10'h300;
  localparam logic [6:0] SLV_ADDR  = 7'h0A;

  logic clk;
  logic rst;
  logic scl;
  wire  sda;
  logic slv_drive = 1'b0;

  i2c_if #(.DATA_WIDTH(DW)) host ();

  i2c_controller #(
    .DATA_WIDTH (DW),
    .CLK_DIV    (CLK_DIV)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .host (host),
    .scl  (scl),
    .sda  (sda)
  );

  assign sda = slv_drive ? 1'b0 : 1'bz;
  pullup (sda);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  // Token: START / STOP, or {1'b0, ack_bit, byte} for each 9-bit slot group
  logic [9:0] exp_q[$];
  logic [9:0] obs_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- slave model / bus monitor ----------------
  logic       slv_present = 1'b1;
  logic [7:0] slv_rdata   = 8'h00;
  logic       prev_scl, prev_sda, scl_s, sda_s;
  logic [7:0] cur_byte;
  int         bit_idx, byte_cnt;
  logic       tx_mode, matched;

  always @(negedge clk) begin
    if (!rst) begin
      slv_drive = 1'b0;
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
      bit_idx   = 0;
      byte_cnt  = 0;
      tx_mode   = 1'b0;
      matched   = 1'b0;
      cur_byte  = 8'h00;
    end else begin
      scl_s = scl;
      sda_s = sda;
      if (prev_scl && scl_s && prev_sda && !sda_s) begin
        obs_q.push_back(TOK_START);
        bit_idx  = 0;
        byte_cnt = 0;
        tx_mode  = 1'b0;
        matched  = 1'b0;
      end else if (prev_scl && scl_s && !prev_sda && sda_s) begin
        obs_q.push_back(TOK_STOP);
        bit_idx   = 0;
        tx_mode   = 1'b0;
        slv_drive = 1'b0;
      end else if (!prev_scl && scl_s) begin
        if (bit_idx < 8) cur_byte = {cur_byte[6:0], sda_s};
        bit_idx++;
        if (bit_idx == 9) begin
          obs_q.push_back({1'b0, sda_s, cur_byte});
          if (byte_cnt == 0)          tx_mode = matched && cur_byte[0];
          else if (tx_mode && sda_s)  tx_mode = 1'b0;
          byte_cnt++;
          bit_idx = 0;
        end
      end else if (prev_scl && !scl_s) begin
        if (bit_idx == 8) begin
          if (byte_cnt == 0) matched = slv_present && (cur_byte[7:1] == SLV_ADDR);
          slv_drive = !tx_mode && matched;
        end else begin
          slv_drive = tx_mode && !slv_rdata[7 - bit_idx];
        end
      end
      prev_scl = scl_s;
      prev_sda = sda_s;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_txn(input logic wr, input logic [6:0] sa, input logic [7:0] ra,
                         input logic [7:0] di, output int cyc, output logic busy_seen);
    @(negedge clk);
    host.wrEn    = wr;
    host.slvAddr = sa;
    host.regAddr = ra;
    host.dataIn  = di;
    host.newTXN  = 1'b1;
    @(negedge clk);
    host.newTXN = 1'b0;
    busy_seen   = host.busy;
    cyc         = 1;
    while (host.done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst          = 1'b1;
    host.newTXN  = 1'b0;
    host.wrEn    = 1'b0;
    host.slvAddr = '0;
    host.regAddr = '0;
    host.dataIn  = '0;
    #1 rst = 1'b0;
    #12;
    n_checks++; if (scl !== 1'b1) begin n_errors++; $display("FAIL reset_scl: got %b expected 1", scl); end
    n_checks++; if (sda !== 1'b1) begin n_errors++; $display("FAIL reset_sda: got %b expected released(1)", sda); end
    n_checks++; if (host.busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy: got %b expected 0", host.busy); end
    n_checks++; if (host.done !== 1'b0) begin n_errors++; $display("FAIL reset_done: got %b expected 0", host.done); end
    n_checks++; if (host.ack_err !== 1'b0) begin n_errors++; $display("FAIL reset_ack_err: got %b expected 0", host.ack_err); end
    n_checks++; if (host.dataOut !== 8'h00) begin n_errors++; $display("FAIL reset_dataOut: got %h expected 00", host.dataOut); end
    n_checks++; if (host.state !== IDLE) begin n_errors++; $display("FAIL reset_state: got %0d expected %0d", host.state, IDLE); end
    @(negedge clk);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    n_checks++; if (obs_q.size() != 0) begin n_errors++; $display("FAIL idle_bus: got %0d tokens expected 0", obs_q.size()); end
    n_checks++; if (scl !== 1'b1 || host.busy !== 1'b0) begin n_errors++; $display("FAIL idle_lines: got scl=%b busy=%b expected 1/0", scl, host.busy); end
  endtask

  task automatic test_write();
    int cyc;
    logic b1;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h014);
    exp_q.push_back(10'h001);
    exp_q.push_back(10'h003);
    exp_q.push_back(TOK_STOP);
    slv_present = 1'b1;
    run_txn(1'b1, 7'h0A, 8'h01, 8'h03, cyc, b1);
    n_checks++; if (b1 !== 1'b1) begin n_errors++; $display("FAIL write_busy: got %b expected 1", b1); end
    n_checks++; if (cyc != 1 + 29 * SLOT) begin n_errors++; $display("FAIL write_cycles: got %0d expected %0d", cyc, 1 + 29 * SLOT); end
    n_checks++; if (host.ack_err !== 1'b0) begin n_errors++; $display("FAIL write_ack_err: got %b expected 0", host.ack_err); end
    n_checks++; if (host.dataOut !== 8'h00) begin n_errors++; $display("FAIL write_dataOut: got %h expected 00", host.dataOut); end
    @(negedge clk);
    n_checks++; if (host.done !== 1'b0 || host.busy !== 1'b0) begin n_errors++; $display("FAIL write_end: got done=%b busy=%b expected 0/0", host.done, host.busy); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL write_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL write_tok%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_read();
    int cyc;
    logic b1;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h014);
    exp_q.push_back(10'h001);
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h015);
    exp_q.push_back(10'h1A5);
    exp_q.push_back(TOK_STOP);
    slv_present = 1'b1;
    slv_rdata   = 8'hA5;
    run_txn(1'b0, 7'h0A, 8'h01, 8'h00, cyc, b1);
    n_checks++; if (cyc != 1 + 39 * SLOT) begin n_errors++; $display("FAIL read_cycles: got %0d expected %0d", cyc, 1 + 39 * SLOT); end
    n_checks++; if (host.dataOut !== 8'hA5) begin n_errors++; $display("FAIL read_dataOut: got %h expected a5", host.dataOut); end
    n_checks++; if (host.ack_err !== 1'b0) begin n_errors++; $display("FAIL read_ack_err: got %b expected 0", host.ack_err); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL read_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL read_tok%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_addr_nack();
    int cyc;
    logic b1;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h114);
    exp_q.push_back(TOK_STOP);
    slv_present = 1'b0;
    run_txn(1'b1, 7'h0A, 8'h01, 8'h03, cyc, b1);
    n_checks++; if (cyc != 1 + 11 * SLOT) begin n_errors++; $display("FAIL nack_cycles: got %0d expected %0d", cyc, 1 + 11 * SLOT); end
    n_checks++; if (host.ack_err !== 1'b1) begin n_errors++; $display("FAIL nack_ack_err: got %b expected 1", host.ack_err); end
    n_checks++; if (host.dataOut !== 8'hA5) begin n_errors++; $display("FAIL nack_dataOut: got %h expected a5", host.dataOut); end
    @(negedge clk);
    n_checks++; if (host.done !== 1'b0 || host.busy !== 1'b0) begin n_errors++; $display("FAIL nack_end: got done=%b busy=%b expected 0/0", host.done, host.busy); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL nack_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL nack_tok%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      end
    end
    slv_present = 1'b1;
  endtask

  task automatic test_back_to_back();
    int cyc;
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h014);
    exp_q.push_back(10'h010);
    exp_q.push_back(10'h011);
    exp_q.push_back(TOK_STOP);
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h014);
    exp_q.push_back(10'h020);
    exp_q.push_back(10'h044);
    exp_q.push_back(TOK_STOP);
    @(negedge clk);
    host.wrEn    = 1'b1;
    host.slvAddr = 7'h0A;
    host.regAddr = 8'h10;
    host.dataIn  = 8'h11;
    host.newTXN  = 1'b1;
    @(negedge clk);
    n_checks++; if (host.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy1: got %b expected 1", host.busy); end
    host.regAddr = 8'h20;
    host.dataIn  = 8'h44;
    cyc = 1;
    while (host.done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 1 + 29 * SLOT) begin n_errors++; $display("FAIL b2b_cycles1: got %0d expected %0d", cyc, 1 + 29 * SLOT); end
    n_checks++; if (host.ack_err !== 1'b0) begin n_errors++; $display("FAIL b2b_ack_err: got %b expected 0", host.ack_err); end
    @(negedge clk);
    n_checks++; if (host.state !== IDLE || host.busy !== 1'b0) begin n_errors++; $display("FAIL b2b_gap: got state=%0d busy=%b expected %0d/0", host.state, host.busy, IDLE); end
    @(negedge clk);
    host.newTXN = 1'b0;
    n_checks++; if (host.busy !== 1'b1) begin n_errors++; $display("FAIL b2b_busy2: got %b expected 1", host.busy); end
    cyc = 1;
    while (host.done !== 1'b1 && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (cyc != 1 + 29 * SLOT) begin n_errors++; $display("FAIL b2b_cycles2: got %0d expected %0d", cyc, 1 + 29 * SLOT); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL b2b_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL b2b_tok%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    logic b1;
    obs_q.delete();
    @(negedge clk);
    host.wrEn    = 1'b1;
    host.slvAddr = 7'h0A;
    host.regAddr = 8'h5A;
    host.dataIn  = 8'hC3;
    host.newTXN  = 1'b1;
    @(negedge clk);
    host.newTXN = 1'b0;
    cyc = 0;
    // First REG bit of 0x5A is 0: wait until SCL low with SDA pulled low
    while (!(host.state == REG && scl === 1'b0 && sda === 1'b0) && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
    end
    n_checks++; if (host.state !== REG) begin n_errors++; $display("FAIL mid_reach_reg: got %0d expected %0d", host.state, REG); end
    rst = 1'b0;
    #1;
    n_checks++; if (scl !== 1'b1) begin n_errors++; $display("FAIL mid_scl: got %b expected 1", scl); end
    n_checks++; if (sda !== 1'b1) begin n_errors++; $display("FAIL mid_sda: got %b expected released(1)", sda); end
    n_checks++; if (host.busy !== 1'b0 || host.state !== IDLE) begin n_errors++; $display("FAIL mid_state: got busy=%b state=%0d expected 0/%0d", host.busy, host.state, IDLE); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    obs_q.delete();
    exp_q.delete();
    exp_q.push_back(TOK_START);
    exp_q.push_back(10'h014);
    exp_q.push_back(10'h022);
    exp_q.push_back(10'h05C);
    exp_q.push_back(TOK_STOP);
    run_txn(1'b1, 7'h0A, 8'h22, 8'h5C, cyc, b1);
    n_checks++; if (cyc != 1 + 29 * SLOT) begin n_errors++; $display("FAIL mid_after_cycles: got %0d expected %0d", cyc, 1 + 29 * SLOT); end
    n_checks++; if (host.ack_err !== 1'b0) begin n_errors++; $display("FAIL mid_after_ack_err: got %b expected 0", host.ack_err); end
    n_checks++; if (obs_q.size() != exp_q.size()) begin n_errors++; $display("FAIL mid_after_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      n_checks++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        n_errors++;
        $display("FAIL mid_after_tok%0d: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 10'h3ff, exp_q[i]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_back_to_back();
    test_reset_mid();
    repeat (4) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
- Single-master I2C controller performing one register write or one register read per transaction.
- Sits between a simple host-side command interface and the on-board I2C bus. It generates START, address/register/data bytes, ACK checks, repeated START and STOP.
- Open-drain SDA; SCL is push-pull with no clock stretching and no multi-master arbitration.

Parameters:
- DATA_WIDTH, 8, byte width for regAddr/dataIn/dataOut; slave address is DATA_WIDTH-1 bits.
- CLK_DIV, 4, system clocks per SCL quarter-period; SCL period = 4*CLK_DIV clk cycles. Must be >= 1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-low reset (rst=0 resets).
- wrEn  input  1  1 = register write, 0 = register read; sampled at transaction start.
- newTXN  input  1  start request; level-sensitive, accepted only in IDLE.
- slvAddr  input  DATA_WIDTH-1  7-bit slave address; latched at start.
- regAddr  input  DATA_WIDTH  target register address; latched at start.
- dataIn  input  DATA_WIDTH  write data; latched at start.
- dataOut  output  DATA_WIDTH  read data; valid when done=1 after a read.
- busy  output  1  high from acceptance until return to IDLE.
- done  output  1  one-clk pulse on transaction completion (success or abort).
- ack_err  output  1  set when any expected slave ACK is NACK; cleared on next acceptance.
- scl  output  1  I2C clock, idles high.
- sda  inout  1  I2C data, open-drain: drive 0 or release (Z); never drive 1.

Behaviour:
- Reset: scl=1, sda released, busy=0, done=0, ack_err=0, dataOut=0, state=IDLE, divider cleared. Reset mid-transaction releases the bus on the same edge with no STOP.
- Acceptance: in IDLE with newTXN=1, latch wrEn/slvAddr/regAddr/dataIn, set busy and clear ack_err next clk. If newTXN is still high on return to IDLE, a new transaction starts.
- Quarter-tick generator: 1-clk tick every CLK_DIV clks, counts phases 0..3 per bit.
  - Phase 0: SCL low, change SDA.
  - Phase 1: SCL rise.
  - Phase 2: sample SDA.
  - Phase 3: SCL high hold.
- States: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP, DONE.
- Write sequence: START, slvAddr+0, ACK, regAddr, ACK, dataIn, ACK, STOP.
- Read sequence: START, slvAddr+0, ACK, regAddr, ACK, RSTART, slvAddr+1, ACK, 8 data bits, master NACK (SDA released), STOP.
- Bit order: MSB first. The address byte is {slvAddr, R/W}.
- START/RSTART: SDA falls while SCL high. STOP: SDA rises while SCL high.
- ACK slot: master releases SDA, samples at phase 2. Sampled 1 is a NACK: set ack_err and go to STOP (skip remaining bytes); dataOut unchanged.
- RDATA: shift sampled bits in; dataOut updates only on full byte, before STOP.
- DONE: done=1 for one clk; busy drops on the same edge as the return to IDLE.
- Inputs changed during busy are ignored.
- Nominal write length: 1 START + 27 bit slots + STOP. Each bit is 4*CLK_DIV clks.

Decomposition:
- Package i2c_pkg: state enum, RW_WRITE=0 / RW_READ=1 constants, phase indices.
- Sub-module i2c_clk_gen: divider producing quarter tick and 2-bit phase, with enable and async active-low reset.

Test Plan:
- Reset: hold rst=0 for 10ns, release -> scl=1, sda=Z, busy=0, dataOut=0; no bus activity with newTXN=0.
- Write: wrEn=1, slvAddr=7'h0A, regAddr=8'h01, dataIn=8'h03, newTXN pulse, slave model ACKs -> bus shows START, 0x14, 0x01, 0x03, STOP; done pulse; ack_err=0.
- Read: wrEn=0, slvAddr=7'h0A, regAddr=8'h01, slave returns 0xA5 -> bytes 0x14, 0x01, RSTART, 0x15, master NACK, STOP; dataOut=8'hA5.
- Address NACK: no slave at 7'h0A -> ack_err=1 after first ACK slot, STOP follows immediately, done pulses, dataOut unchanged.
- Reset mid-transaction: assert rst during the REG byte -> scl=1 and sda released immediately; a new write afterwards completes normally.
- Back-to-back: hold newTXN=1 for two transactions -> second START only after first STOP plus DONE; input changes during busy are not reflected on the bus.
